// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, Rcon, GF(2^8) helpers, FSM states.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        INIT,
        ROUND,
        FINAL
    } state_e;

    // Round constants for key-expansion rounds 1..10 (index r-1).
    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX_TBL = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] INV_SBOX_TBL = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[x];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[x];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product; with a constant b it folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// InvMixColumns on one 32-bit column; byte 0 is bits 31:24.
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign col_o[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign col_o[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign col_o[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign col_o[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock, on-chip key schedule.
// Optional key cache: define AES128_DEC_KEYCACHE_EN to skip key expansion
// when a block arrives with the same key as the last fully expanded one.
module aes128_decrypt
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_src,
    input  logic [127:0] in_key,
    output logic [127:0] out_result,
    output logic         write,
    output logic         busy
);

    // Byte i (0 = first) lives at bits 127-8i; column c = i/4, row = i%4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] out_q, out_d;
    logic         write_q, write_d;
    logic [127:0] rk_q [0:10];

    logic         accept;
    logic         cache_hit;
    logic [127:0] rk_sel;
    logic [127:0] kx_prev;
    logic [31:0]  kx_temp;
    logic [31:0]  kx_w0, kx_w1, kx_w2, kx_w3;
    logic [127:0] sr_sb;
    logic [127:0] add_rk;
    logic [127:0] mixed;

    assign accept = (state_q == IDLE) && in_valid;

    // The counter always points at the round key the current state consumes:
    // 10 in INIT, 9..1 in ROUND, 0 in FINAL.
    assign rk_sel = rk_q[rnd_q];

    // Key expansion for round rnd_q from rk[rnd_q-1].
    assign kx_prev = rk_q[rnd_q - 4'd1];
    assign kx_temp = {sbox(kx_prev[23:16]), sbox(kx_prev[15:8]),
                      sbox(kx_prev[7:0]),   sbox(kx_prev[31:24])}
                   ^ {RCON[rnd_q - 4'd1], 24'h000000};
    assign kx_w0 = kx_prev[127:96] ^ kx_temp;
    assign kx_w1 = kx_prev[95:64]  ^ kx_w0;
    assign kx_w2 = kx_prev[63:32]  ^ kx_w1;
    assign kx_w3 = kx_prev[31:0]   ^ kx_w2;

    // Shared round datapath; FINAL uses add_rk directly, ROUND adds InvMixColumns.
    assign sr_sb  = inv_sub_bytes(inv_shift_rows(blk_q));
    assign add_rk = sr_sb ^ rk_sel;

    for (genvar g = 0; g < 4; g++) begin : g_imc
        aes_inv_mix_column u_imc (
            .col_i (add_rk[127 - 32*g -: 32]),
            .col_o (mixed[127 - 32*g -: 32])
        );
    end

`ifdef AES128_DEC_KEYCACHE_EN
    logic [127:0] last_key_q;
    logic         key_vld_q;
    logic         keyexp_done;

    assign keyexp_done = (state_q == KEYEXP) && (rnd_q == 4'd10);
    assign cache_hit   = key_vld_q && (in_key == last_key_q);

    // Remember the key whose schedule is now complete in the round-key file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_key_q <= '0;
            key_vld_q  <= 1'b0;
        end else if (keyexp_done) begin
            last_key_q <= rk_q[0];
            key_vld_q  <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Next-state and datapath selection for the inverse-cipher sequence.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        blk_d   = blk_q;
        rnd_d   = rnd_q;
        out_d   = out_q;
        write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d = in_src;
                    if (cache_hit) begin
                        rnd_d   = 4'd10;
                        state_d = INIT;
                    end else begin
                        rnd_d   = 4'd1;
                        state_d = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                if (rnd_q == 4'd10) state_d = INIT;
                else                rnd_d   = rnd_q + 4'd1;
            end
            INIT: begin
                blk_d   = blk_q ^ rk_sel;
                rnd_d   = 4'd9;
                state_d = ROUND;
            end
            ROUND: begin
                blk_d = mixed;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = FINAL;
            end
            FINAL: begin
                out_d   = add_rk;
                write_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and data registers, cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            rnd_q   <= '0;
            out_q   <= '0;
            write_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            blk_q   <= blk_d;
            rnd_q   <= rnd_d;
            out_q   <= out_d;
            write_q <= write_d;
        end
    end

    // Round-key file: rk[0] loads the cipher key, rk[1..10] fill during KEYEXP.
    // NOTE: no reset here; every entry is written before it is read, and the
    // cache valid bit (which is reset) guards any reuse of the stored schedule.
    always_ff @(posedge clock) begin
        if (accept) begin
            rk_q[0] <= in_key;
        end else if (state_q == KEYEXP) begin
            rk_q[rnd_q] <= {kx_w0, kx_w1, kx_w2, kx_w3};
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_result = out_q;
    assign write      = write_q;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Self-checking bench for aes128_decrypt: FIPS vectors, timing, reset and
// an encrypt-then-decrypt loopback against a behavioural AES encryptor.
module tb_aes128_decrypt;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_src;
    logic [127:0] in_key;
    logic [127:0] out_result;
    logic         write;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb [256];

`ifdef AES128_DEC_KEYCACHE_EN
    localparam int LAT_HIT = 11;
`else
    localparam int LAT_HIT = 21;
`endif
    localparam int LAT_MISS  = 21;
    localparam int LAT_LIMIT = 40;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes128_decrypt dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_src     (in_src),
        .in_key     (in_key),
        .out_result (out_result),
        .write      (write),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural AES-128 encryptor ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse, then affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            xb  = 8'(x);
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [7:0]   x;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127 - 8*i -: 8];
            s[i] = pt[127 - 8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                x      = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[x];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            // SubBytes + ShiftRows: row i%4 rotates left by its row number.
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic start(input logic [127:0] key, input logic [127:0] src);
        in_key   = key;
        in_src   = src;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until write is seen; bounded.
    task automatic wait_write(output int lat);
        lat = 0;
        while (write !== 1'b1 && lat < LAT_LIMIT) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] src,
                             input logic [127:0] exp_pt, input int exp_lat);
        int lat;
        start(key, src);
        wait_write(lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_pt"}, out_result, exp_pt);
        check_bit({tag, "_ready_on_write"}, in_ready, 1'b1);
    endtask

    initial begin
        int           lat;
        int           ready_hi;
        int           busy_lo;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] prev_key;
        logic         reuse;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_src   = '0;
        in_key   = '0;
        build_sbox();

        // Reset state.
        repeat (3) @(negedge clock);
        check_bit("rst_ready", in_ready, 1'b1);
        check_bit("rst_write", write, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check("rst_out", out_result, '0);
        reset = 1'b1;
        @(negedge clock);

        // FIPS-197 C.1, cold.
        run_block("c1", C1_KEY, C1_CT, C1_PT, LAT_MISS);
        @(negedge clock);
        check_bit("c1_write_one_cycle", write, 1'b0);
        check("c1_out_hold", out_result, C1_PT);

        // FIPS-197 App. B twice back to back, second accepted on the write cycle.
        run_block("b_first", B_KEY, B_CT, B_PT, LAT_MISS);
        run_block("b_second", B_KEY, B_CT, B_PT, LAT_HIT);
        @(negedge clock);

        // in_valid held high through a whole operation: one acceptance only.
        key = rand128();
        pt  = rand128();
        in_key   = key;
        in_src   = encrypt(pt, key);
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lat      = 0;
        ready_hi = 0;
        busy_lo  = 0;
        while (write !== 1'b1 && lat < LAT_LIMIT) begin
            if (in_ready) ready_hi++;
            if (!busy) busy_lo++;
            @(negedge clock);
            lat++;
        end
        in_valid = 1'b0;
        check("held_ready_low_cycles", 128'(ready_hi), 128'(0));
        check("held_busy_low_cycles", 128'(busy_lo), 128'(0));
        check("held_pt", out_result, pt);
        check_bit("held_ready_on_write", in_ready, 1'b1);
        @(negedge clock);
        check_bit("held_no_second_accept", busy, 1'b0);

        // Reset at E15 of a C.1 block, then C.1 must pay the full latency.
        start(C1_KEY, C1_CT);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check_bit("midrst_ready", in_ready, 1'b1);
        check_bit("midrst_write", write, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check("midrst_out", out_result, '0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_block("c1_after_rst", C1_KEY, C1_CT, C1_PT, LAT_MISS);

        // Loopback: random pairs through the model encryptor, then the DUT,
        // issued back to back; about a quarter reuse the previous key.
        prev_key = C1_KEY;
        for (int i = 0; i < 1000; i++) begin
            reuse = (i > 0) && ($urandom_range(3) == 0);
            key   = reuse ? prev_key : rand128();
            pt    = rand128();
            start(key, encrypt(pt, key));
            wait_write(lat);
            check("loop_lat", 128'(lat), 128'(reuse ? LAT_HIT : LAT_MISS));
            check("loop_pt", out_result, pt);
            prev_key = key;
        end
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt.md
# aes128_decrypt

Iterative AES-128 decryption core (FIPS-197 inverse cipher), the receive-side counterpart of the team's AES-128 encryption core. It accepts one 128-bit ciphertext block plus its 128-bit key, expands the key schedule on chip, runs the ten inverse rounds at one round per clock and presents the plaintext with a one-cycle write strobe. Byte and word ordering match the encryptor: bit 127 is the first byte, and column 0 is bits 127:96. A block encrypted by the encryptor and fed here with the same key returns the original source.

## Interface
No parameters; the key length is fixed at 128 bits.
- clock  input  1  sole clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  in_src and in_key are valid
- in_ready  output  1  core idle and able to accept a block
- in_src  input  128  ciphertext block
- in_key  input  128  cipher key, as given to the encryptor
- out_result  output  128  plaintext; registered, holds until the next write
- write  output  1  one-cycle pulse marking a new out_result
- busy  output  1  high from acceptance until the cycle write is asserted

## Operation
- Accept: a transfer happens on an edge where in_valid and in_ready are both high.
  - Capture in_src into the state register and in_key into round key 0.
  - Go to KEYEXP, or straight to INIT on a key-cache hit (see Configuration).
- States:
  - IDLE: in_ready=1. On accept, go to KEYEXP, or to INIT on a cache hit.
  - KEYEXP: one round key per cycle, for r=1..10. Each uses the standard expansion: RotWord, SubWord, Rcon[r], then a chained XOR over the words of rk[r-1]. Round keys are stored in an 11×128 register file. After r=10, go to INIT.
  - INIT: state = state ^ rk[10]. Set r=9 and go to ROUND.
  - ROUND: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]), with r decrementing 9..1. After r=1, go to FINAL.
  - FINAL: out_result = InvSubBytes(InvShiftRows(state)) ^ rk[0]. write=1 for the next cycle; go to IDLE.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored; there is no queuing.
- write has no backpressure. The consumer must take out_result on the write cycle or before the next write.
- Reset is asserted asynchronously, released synchronously, and may arrive at any point, including mid-operation:
  - state goes to IDLE, in_ready=1, busy=0, write=0;
  - out_result, the state register and the round counter go to 0;
  - the key cache is invalidated.

## Timing
- Let the acceptance edge be E0.
- Without a cache hit:
  - KEYEXP occupies E1..E10, INIT is at E11, ROUND at E12..E20, FINAL at E21.
  - write is high in the cycle after E21. Latency is 21 cycles, edge to write.
- With a cache hit: INIT at E1, ROUND at E2..E10, FINAL at E11. Latency is 11 cycles.
- in_ready returns high in the same cycle write is high, so a new block may be accepted on that edge.
- Back-to-back throughput is one block per 22 cycles, or 12 with a cache hit.
- busy = (state != IDLE).
- Round-counter arithmetic is 4-bit unsigned with no wrap. It is only valid for r=0..10.

## Configuration
- AES128_DEC_KEYCACHE_EN defined:
  - Keep a 128-bit last-key register plus a valid bit. Both are set when KEYEXP completes.
  - On accept, if the valid bit is set and in_key equals the last key, skip KEYEXP and reuse the stored schedule.
  - The valid bit is cleared by reset.
- AES128_DEC_KEYCACHE_EN undefined: every block runs KEYEXP, and latency is always 21 cycles.

## Structure
- Package aes_pkg holds:
  - the forward S-box function, used by key expansion;
  - the inverse S-box function;
  - the Rcon constant array (10 × 8 bits);
  - xtime and gf_mul helpers;
  - the FSM state enum (IDLE, KEYEXP, INIT, ROUND, FINAL).
- Sub-module aes_inv_mix_column: combinational on one 32-bit column (multiply by 0e/0b/0d/09), instantiated four times.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in_src 69c4e0d86a7b0430d8cdb78070b4c55a → out_result 00112233445566778899aabbccddeeff, with write exactly 21 cycles after acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, in_src 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
- Same key twice back-to-back, accepting on the write cycle:
  - with AES128_DEC_KEYCACHE_EN, the second result arrives 11 cycles after its acceptance;
  - without it, 21 cycles.
- in_valid held high throughout the run → exactly one acceptance. in_ready stays 0 until the write cycle.
- reset asserted at E15 → in_ready=1, write=0, out_result=0 immediately. A subsequent C.1 block must run the full 21-cycle latency, proving the cache was invalidated.
- Loopback: 1000 random key/source pairs through the encryptor then this core → out_result == original in_src on every write.
